// File: rtl/mips_encode.sv
// Converts ALU-level operation requests into 32-bit MIPS R/I-type instruction words.
// Encoded words go into a first-word-fall-through FIFO. Unencodable requests are flagged and counted.
module mips_encode #(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               alu_op,
    input  logic                     imm_sel,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    input  logic [4:0]               rd,
    input  logic [15:0]              imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic                     except,
    output logic [ERRW-1:0]          err_count,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          except_reg;
    logic [ERRW-1:0] err_reg;

    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic        r_ok;
    logic        i_ok;
    logic        enc_ok;
    logic [31:0] enc_word;

    logic accept;
    logic push;
    logic pop;

    // Each op maps to an R-type funct and, where one exists, an I-type opcode.
    always_comb begin
        funct  = 6'h00;
        opcode = 6'h00;
        r_ok   = 1'b1;
        i_ok   = 1'b1;
        case (alu_op)
            3'b010:  begin funct = 6'h20; opcode = 6'h08; end
            3'b011:  begin funct = 6'h22; i_ok = 1'b0;    end
            3'b100:  begin funct = 6'h24; opcode = 6'h0C; end
            3'b101:  begin funct = 6'h25; opcode = 6'h0D; end
            3'b110:  begin funct = 6'h27; i_ok = 1'b0;    end
            3'b111:  begin funct = 6'h26; opcode = 6'h0E; end
            default: begin r_ok = 1'b0;   i_ok = 1'b0;    end
        endcase
        enc_ok   = imm_sel ? i_ok : r_ok;
        enc_word = imm_sel ? {opcode, rs, rt, imm}
                           : {6'h00, rs, rt, rd, 5'b00000, funct};
    end

    assign in_ready  = (count_reg != CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign accept    = in_valid & in_ready;
    assign push      = accept & enc_ok;
    assign pop       = out_valid & out_ready;

    assign out_instr = out_valid ? mem_reg[rd_ptr_reg] : 32'h0000_0000;
    assign count     = count_reg;
    assign except    = except_reg;
    assign err_count = err_reg;

    // Storage is not reset; the head is gated to zero whenever the FIFO is empty.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= enc_word;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            except_reg <= 1'b0;
            err_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            except_reg <= accept & ~enc_ok;
            if (accept && !enc_ok && !(&err_reg)) begin
                err_reg <= err_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_encode.sv
// Self-checking bench for mips_encode: vector table, corner-case sequences and random traffic
// compared against a queue-based reference model.
module tb_mips_encode;

    localparam int DEPTH   = 4;
    localparam int ERR_MAX = 255;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_op;
    logic        imm_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        except;
    logic [7:0]  err_count;
    logic [2:0]  count;

    mips_encode #(.DEPTH(DEPTH), .ERRW(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .imm_sel(imm_sel),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .except(except), .err_count(err_count), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] q[$];
    int          err_m = 0;
    logic        exc_m = 1'b0;

    // Encoding tables indexed by alu_op; -1 marks "no such instruction".
    int funct_tab [8] = '{-1, -1, 'h20, 'h22, 'h24, 'h25, 'h27, 'h26};
    int opc_tab   [8] = '{-1, -1, 'h08, -1, 'h0C, 'h0D, -1, 'h0E};

    typedef struct {
        logic [2:0]  op;
        logic        isel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] word;
        logic        ok;
    } vec_t;

    vec_t vecs [14];

    function automatic logic ref_encode(input logic [2:0] op, input logic isel,
                                        input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] c, input logic [15:0] im,
                                        output logic [31:0] w);
        longint v;
        w = 32'h0;
        if (isel) begin
            if (opc_tab[op] < 0) return 1'b0;
            v = longint'(opc_tab[op]) * (64'd1 << 26) + longint'(a) * (64'd1 << 21)
              + longint'(b) * (64'd1 << 16) + longint'(im);
        end else begin
            if (funct_tab[op] < 0) return 1'b0;
            v = longint'(a) * (64'd1 << 21) + longint'(b) * (64'd1 << 16)
              + longint'(c) * (64'd1 << 11) + longint'(funct_tab[op]);
        end
        w = v[31:0];
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs, advance model, check registered flags.
    task automatic step(input logic v, input logic [2:0] op, input logic isel,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                        input logic [15:0] im, input logic ordy, output logic acc);
        logic [31:0] w;
        logic        ok;
        logic        pop;
        @(negedge clock);
        in_valid = v; alu_op = op; imm_sel = isel;
        rs = a; rt = b; rd = c; imm = im; out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("count", 32'(count), 32'(q.size()));
        chk("out_instr", out_instr, (q.size() != 0) ? q[0] : 32'h0);
        acc = v && (q.size() != DEPTH);
        pop = ordy && (q.size() != 0);
        ok  = ref_encode(op, isel, a, b, c, im, w);
        @(posedge clock);
        #1;
        if (pop) void'(q.pop_front());
        if (acc && ok) q.push_back(w);
        exc_m = acc && !ok;
        if (exc_m && err_m != ERR_MAX) err_m++;
        chk("except", 32'(except), 32'(exc_m));
        chk("err_count", 32'(err_count), 32'(err_m));
        $display("cyc v=%0b op=%0d isel=%0b ordy=%0b acc=%0b cnt=%0d instr=0x%08h exc=%0b err=%0d",
                 v, op, isel, ordy, acc, count, out_instr, except, err_count);
    endtask

    // Reset for one cycle while offering an unencodable request that must be ignored.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b1; alu_op = 3'b000; out_ready = 1'b0;
        @(posedge clock);
        #1;
        q.delete(); err_m = 0; exc_m = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_except", 32'(except), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        $display("reset applied: cnt=%0d out_valid=%0b err=%0d", count, out_valid, err_count);
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        logic acc;
        int   budget;

        vecs[0]  = '{3'b010, 1'b0, 5'd1,  5'd2,  5'd3,  16'hFFFF, 32'h0022_1820, 1'b1};
        vecs[1]  = '{3'b010, 1'b1, 5'd4,  5'd5,  5'd9,  16'hFFFF, 32'h2085_FFFF, 1'b1};
        vecs[2]  = '{3'b111, 1'b1, 5'd0,  5'd31, 5'd0,  16'h00AB, 32'h381F_00AB, 1'b1};
        vecs[3]  = '{3'b110, 1'b0, 5'd7,  5'd8,  5'd9,  16'h0000, 32'h00E8_4827, 1'b1};
        vecs[4]  = '{3'b011, 1'b1, 5'd1,  5'd2,  5'd3,  16'h1234, 32'h0,         1'b0};
        vecs[5]  = '{3'b011, 1'b0, 5'd10, 5'd11, 5'd12, 16'h5555, 32'h014B_6022, 1'b1};
        vecs[6]  = '{3'b100, 1'b0, 5'd31, 5'd31, 5'd31, 16'h0000, 32'h03FF_F824, 1'b1};
        vecs[7]  = '{3'b101, 1'b0, 5'd0,  5'd0,  5'd0,  16'hFFFF, 32'h0000_0025, 1'b1};
        vecs[8]  = '{3'b111, 1'b0, 5'd1,  5'd0,  5'd2,  16'h0000, 32'h0020_1026, 1'b1};
        vecs[9]  = '{3'b100, 1'b1, 5'd3,  5'd6,  5'd9,  16'h1234, 32'h3066_1234, 1'b1};
        vecs[10] = '{3'b101, 1'b1, 5'd31, 5'd0,  5'd0,  16'h8000, 32'h37E0_8000, 1'b1};
        vecs[11] = '{3'b110, 1'b1, 5'd2,  5'd2,  5'd2,  16'h0001, 32'h0,         1'b0};
        vecs[12] = '{3'b001, 1'b0, 5'd2,  5'd2,  5'd2,  16'h0001, 32'h0,         1'b0};
        vecs[13] = '{3'b000, 1'b1, 5'd2,  5'd2,  5'd2,  16'h0001, 32'h0,         1'b0};

        reset = 1'b1; in_valid = 1'b0; alu_op = 3'b000; imm_sel = 1'b0;
        rs = '0; rt = '0; rd = '0; imm = '0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("init_count", 32'(count), 32'd0);
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_except", 32'(except), 32'd0);
        chk("init_err_count", 32'(err_count), 32'd0);
        chk("init_out_instr", out_instr, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Vector table: each word must be at the head right after its accept edge.
        for (int i = 0; i < 14; i++) begin
            step(1'b1, vecs[i].op, vecs[i].isel, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                 vecs[i].imm, 1'b1, acc);
            chk("vec_accept", 32'(acc), 32'd1);
            if (vecs[i].ok) chk("vec_word", out_instr, vecs[i].word);
            chk("vec_except", 32'(except), 32'(!vecs[i].ok));
        end
        step(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, acc);
        chk("drain_empty", 32'(count), 32'd0);

        // Fill with the consumer stalled, then release it while a fifth request waits.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b010, 1'b0, 5'(i), 5'(i + 1), 5'(i + 2), 16'h0, 1'b0, acc);
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 3'b101, 1'b0, 5'd20, 5'd21, 5'd22, 16'h0, 1'b0, acc);
        chk("full_no_accept", 32'(acc), 32'd0);
        chk("full_hold_instr", out_instr, 32'h0001_1020);
        budget = 0;
        acc = 1'b0;
        while (!acc && budget < 20) begin
            step(1'b1, 3'b101, 1'b0, 5'd20, 5'd21, 5'd22, 16'h0, 1'b1, acc);
            budget++;
        end
        chk("fifth_accepted", 32'(acc), 32'd1);
        chk("fifth_delay", 32'(budget), 32'd2);
        budget = 0;
        while (q.size() != 0 && budget < 20) begin
            step(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, acc);
            budget++;
        end
        chk("drain_done", 32'(count), 32'd0);

        // Error counter saturation with nothing enqueued.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 3'b000, 1'(i % 2), 5'd1, 5'd1, 5'd1, 16'h0, 1'b1, acc);
        end
        chk("sat_err_count", 32'(err_count), 32'd255);
        chk("sat_count", 32'(count), 32'd0);

        // Reset mid-operation with three buffered words and a pending error pulse.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b100, 1'b1, 5'd3, 5'd4, 5'd0, 16'(i), 1'b0, acc);
        end
        chk("pre_rst_count", 32'(count), 32'd3);
        do_reset();
        step(1'b1, 3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, acc);
        chk("post_rst_add", out_instr, 32'h0022_1820);
        step(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, acc);

        // Random traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                 1'($urandom_range(0, 2) != 0), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
